// File: rtl/adc_qsys_ram_pkg.sv
// Shared types and constants for the sample-RAM arbiter slice.
package adc_qsys_ram_pkg;

    localparam int RAM_ADDR_W = 15;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_DEPTH  = 32000;
    localparam int RAM_BE_W   = RAM_DATA_W / 8;

    typedef enum logic {
        PRIO_RR     = 1'b0,
        PRIO_FIXED0 = 1'b1
    } prio_mode_e;

    typedef struct packed {
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_BE_W-1:0]   be;
        logic [RAM_DATA_W-1:0] wdata;
        logic                  rd;
        logic                  wr;
    } mem_req_t;

endpackage

// File: rtl/adc_qsys_rr_grant2.sv
// Two-way grant: round-robin or master-0 fixed priority, with the last_grant register.
module adc_qsys_rr_grant2
    import adc_qsys_ram_pkg::*;
#(
    parameter prio_mode_e MODE = PRIO_RR
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

    // last_grant = 1 means master 1 won most recently, so master 0 wins the next tie.
    logic last_grant;

    always_comb begin
        grant0 = ~rst & req0 & (~req1 | (MODE == PRIO_FIXED0) | last_grant);
        grant1 = ~rst & req1 & ~grant0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant0 | grant1) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/adc_qsys_ram_arbiter.sv
// Two-master arbiter for the single-port sample RAM: request mux, read tagging, out-of-range guard.
module adc_qsys_ram_arbiter
    import adc_qsys_ram_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,
    parameter int DEPTH     = RAM_DEPTH,
    parameter int PRIO_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [15:0]         oob_count,
    output logic                oob_irq,
    input  logic                oob_clear
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Handshake: a master's request (read|write) is accepted in the cycle its
    // waitrequest is low; it must hold address/data stable until then. Read data
    // comes back exactly one cycle after acceptance with readdatavalid high.
    logic     req0, req1, grant0, grant1, any_grant;
    logic     oob_hit, is_read;
    logic     rd_pend, rd_tag, rd_oob;
    mem_req_t req0_s, req1_s, sel;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    adc_qsys_rr_grant2 #(
        .MODE (PRIO_MODE == 1 ? PRIO_FIXED0 : PRIO_RR)
    ) u_grant (
        .clk    (clk),
        .rst    (reset),
        .req0   (req0),
        .req1   (req1),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_comb begin
        req0_s       = '0;
        req0_s.addr  = m0_address;
        req0_s.be    = m0_byteenable;
        req0_s.wdata = m0_writedata;
        req0_s.rd    = m0_read;
        req0_s.wr    = m0_write;
        req1_s       = '0;
        req1_s.addr  = m1_address;
        req1_s.be    = m1_byteenable;
        req1_s.wdata = m1_writedata;
        req1_s.rd    = m1_read;
        req1_s.wr    = m1_write;
        sel          = grant1 ? req1_s : req0_s;
    end

    assign any_grant = grant0 | grant1;
    assign oob_hit   = any_grant & ({1'b0, sel.addr} >= DEPTH_L);
    assign is_read   = sel.rd & ~sel.wr;

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    // Out-of-range accesses are accepted but never reach the RAM.
    assign mem_chipselect = any_grant & ~oob_hit;
    assign mem_write      = mem_chipselect & sel.wr;
    assign mem_address    = sel.addr;
    assign mem_byteenable = sel.be;
    assign mem_writedata  = sel.wdata;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
            rd_oob  <= 1'b0;
        end else begin
            rd_pend <= any_grant & is_read;
            rd_tag  <= grant1;
            rd_oob  <= oob_hit;
        end
    end

    assign m0_readdatavalid = rd_pend & ~rd_tag;
    assign m1_readdatavalid = rd_pend & rd_tag;
    assign m0_readdata      = (m0_readdatavalid & ~rd_oob) ? mem_readdata : '0;
    assign m1_readdata      = (m1_readdatavalid & ~rd_oob) ? mem_readdata : '0;

    // A new out-of-range hit beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob_count <= 16'h0;
            oob_irq   <= 1'b0;
        end else if (oob_hit) begin
            oob_irq <= 1'b1;
            if (oob_clear) begin
                oob_count <= 16'h1;
            end else if (oob_count != 16'hFFFF) begin
                oob_count <= oob_count + 16'h1;
            end
        end else if (oob_clear) begin
            oob_count <= 16'h0;
            oob_irq   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_qsys_ram_arbiter.sv
// Directed bench: round-robin DUT with a RAM model, plus a fixed-priority DUT for the contention check.
module tb_adc_qsys_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        oob_clear;

    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [14:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken, oob_irq;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata;
    logic [15:0] oob_count;

    logic        f_m0_waitrequest, f_m0_readdatavalid, f_m1_waitrequest, f_m1_readdatavalid;
    logic [31:0] f_m0_readdata, f_m1_readdata;
    logic [14:0] f_mem_address;
    logic        f_mem_chipselect, f_mem_write, f_mem_clken, f_oob_irq;
    logic [3:0]  f_mem_byteenable;
    logic [31:0] f_mem_writedata;
    logic [15:0] f_oob_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_qsys_ram_arbiter #(.PRIO_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .oob_count(oob_count), .oob_irq(oob_irq), .oob_clear(oob_clear)
    );

    adc_qsys_ram_arbiter #(.PRIO_MODE(1)) dut_fixed (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(f_m0_waitrequest), .m0_readdata(f_m0_readdata),
        .m0_readdatavalid(f_m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(f_m1_waitrequest), .m1_readdata(f_m1_readdata),
        .m1_readdatavalid(f_m1_readdatavalid),
        .mem_address(f_mem_address), .mem_chipselect(f_mem_chipselect),
        .mem_write(f_mem_write), .mem_byteenable(f_mem_byteenable),
        .mem_writedata(f_mem_writedata), .mem_clken(f_mem_clken),
        .mem_readdata(32'h0),
        .oob_count(f_oob_count), .oob_irq(f_oob_irq), .oob_clear(oob_clear)
    );

    // Single-port RAM model with byte enables and one cycle of read latency.
    logic [31:0] ram [0:31999];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
        oob_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        m0_read = 1'b1;
        m1_read = 1'b1;
        @(negedge clk); #1;
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_clken", 32'(mem_clken), 32'd1);
        chk("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("rst_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        chk("rst_m0_rdata", m0_readdata, 32'd0);
        chk("rst_oob_count", 32'(oob_count), 32'd0);
        chk("rst_oob_irq", 32'(oob_irq), 32'd0);

        // m0 writes DEADBEEF to address 5
        @(negedge clk);
        reset = 1'b0;
        idle();
        m0_write = 1'b1; m0_address = 15'd5; m0_writedata = 32'hDEADBEEF;
        #1;
        chk("wr_cs", 32'(mem_chipselect), 32'd1);
        chk("wr_write", 32'(mem_write), 32'd1);
        chk("wr_addr", 32'(mem_address), 32'd5);
        chk("wr_wdata", mem_writedata, 32'hDEADBEEF);
        chk("wr_m0_wait", 32'(m0_waitrequest), 32'd0);

        // m1 reads it back one cycle later
        @(negedge clk);
        idle();
        m1_read = 1'b1; m1_address = 15'd5;
        #1;
        chk("rd_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("rd_cs", 32'(mem_chipselect), 32'd1);
        chk("rd_write", 32'(mem_write), 32'd0);
        chk("rd_m0_rdv_after_wr", 32'(m0_readdatavalid), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("rd_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("rd_m1_rdata", m1_readdata, 32'hDEADBEEF);
        chk("rd_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("rd_m0_rdata", m0_readdata, 32'd0);
        @(negedge clk); #1;
        chk("rd_m1_rdv_drop", 32'(m1_readdatavalid), 32'd0);

        // Both masters contend for 4 cycles; last grant was m1, so m0 goes first
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            m0_read = 1'b1; m0_address = 15'd1;
            m1_read = 1'b1; m1_address = 15'd2;
            #1;
            chk($sformatf("rr_m0_wait_%0d", k), 32'(m0_waitrequest), 32'(k % 2));
            chk($sformatf("rr_m1_wait_%0d", k), 32'(m1_waitrequest), 32'((k + 1) % 2));
            chk($sformatf("rr_addr_%0d", k), 32'(mem_address), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr_m0_rdv_%0d", k), 32'(m0_readdatavalid), 32'(k % 2));
            chk($sformatf("rr_m1_rdv_%0d", k), 32'(m1_readdatavalid), (k == 2) ? 32'd1 : 32'd0);
            chk($sformatf("fx_m0_wait_%0d", k), 32'(f_m0_waitrequest), 32'd0);
            chk($sformatf("fx_m1_wait_%0d", k), 32'(f_m1_waitrequest), 32'd1);
        end
        @(negedge clk);
        idle();
        #1;
        chk("rr_tail_m1_rdv", 32'(m1_readdatavalid), 32'd1);

        // m1 reads the first out-of-range address
        @(negedge clk);
        idle();
        m1_read = 1'b1; m1_address = 15'd32000;
        #1;
        chk("oob_cs", 32'(mem_chipselect), 32'd0);
        chk("oob_write", 32'(mem_write), 32'd0);
        chk("oob_m1_wait", 32'(m1_waitrequest), 32'd0);
        @(negedge clk);
        idle();
        oob_clear = 1'b1;
        #1;
        chk("oob_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("oob_m1_rdata", m1_readdata, 32'd0);
        chk("oob_count_1", 32'(oob_count), 32'd1);
        chk("oob_irq_1", 32'(oob_irq), 32'd1);
        @(negedge clk);
        idle();
        #1;
        chk("oob_clr_count", 32'(oob_count), 32'd0);
        chk("oob_clr_irq", 32'(oob_irq), 32'd0);

        // Out-of-range write together with clear: the new hit wins
        @(negedge clk);
        idle();
        m0_write = 1'b1; m0_address = 15'd32767; m0_writedata = 32'h11111111;
        oob_clear = 1'b1;
        #1;
        chk("oobw_cs", 32'(mem_chipselect), 32'd0);
        chk("oobw_write", 32'(mem_write), 32'd0);
        chk("oobw_m0_wait", 32'(m0_waitrequest), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("oobw_count", 32'(oob_count), 32'd1);
        chk("oobw_irq", 32'(oob_irq), 32'd1);
        chk("oobw_m0_rdv", 32'(m0_readdatavalid), 32'd0);

        // read+write together is a write; low two bytes of address 5 become 5555
        @(negedge clk);
        idle();
        m1_read = 1'b1; m1_write = 1'b1; m1_address = 15'd5;
        m1_byteenable = 4'b0011; m1_writedata = 32'hAAAA5555;
        #1;
        chk("rw_write", 32'(mem_write), 32'd1);
        chk("rw_m1_wait", 32'(m1_waitrequest), 32'd0);
        @(negedge clk);
        idle();
        m0_read = 1'b1; m0_address = 15'd5;
        #1;
        chk("rw_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        chk("b2b_rd_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("b2b_rd_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        idle();
        m1_write = 1'b1; m1_address = 15'd6; m1_writedata = 32'h00000001;
        #1;
        chk("b2b_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("b2b_m0_rdata", m0_readdata, 32'hDEAD5555);
        chk("b2b_wr_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("b2b_wr_write", 32'(mem_write), 32'd1);
        @(negedge clk);
        idle();
        #1;
        chk("b2b_tail_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("b2b_tail_m1_rdv", 32'(m1_readdatavalid), 32'd0);

        // m0 read granted, then reset lands before the data would return
        @(negedge clk);
        idle();
        m0_read = 1'b1; m0_address = 15'd5;
        #1;
        chk("rstrd_m0_wait", 32'(m0_waitrequest), 32'd0);
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        chk("rstrd_m0_rdv_in_rst", 32'(m0_readdatavalid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstrd_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("rstrd_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        chk("rstrd_oob_count", 32'(oob_count), 32'd0);
        chk("rstrd_oob_irq", 32'(oob_irq), 32'd0);
        @(negedge clk);
        m0_read = 1'b1; m0_address = 15'd1;
        m1_read = 1'b1; m1_address = 15'd2;
        #1;
        chk("rstrd_first_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("rstrd_first_m1_wait", 32'(m1_waitrequest), 32'd1);
        @(negedge clk);
        idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_qsys_ram_arbiter.md
Name: adc_qsys_ram_arbiter

Overview:
- Two-master arbiter sharing the single-port 32-bit on-chip sample RAM (32000 words, 15-bit word address, byte enables, 1-cycle read latency).
- Master 0 is the ADC capture engine; master 1 is the NIOS data master.
- Issues at most one RAM access per clock, returns read data with a valid strobe, and guards against out-of-range addresses.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- DEPTH, 32000, number of valid words; addresses >= DEPTH are out of range.
- PRIO_MODE, 0, 0 = round-robin; 1 = master 0 has fixed priority.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_byteenable  in  DATA_W/8  master 0 byte enables.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 request not accepted this cycle.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  master 0 read data valid.
- m1_*  same set as m0_*, for master 1.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after the address is registered.
- oob_count  out  16  count of out-of-range accesses, saturating.
- oob_irq  out  1  sticky out-of-range flag.
- oob_clear  in  1  clears oob_irq and oob_count.

Behaviour:
- Request: mN_req = mN_read | mN_write. read and write asserted together is treated as a write.
- Grant (combinational from requests and registered state last_grant):
  - Only one master requesting: that master wins.
  - Both requesting, PRIO_MODE=0: the master != last_grant wins.
  - Both requesting, PRIO_MODE=1: master 0 always wins.
  - last_grant updates only on a cycle with a grant.
- mN_waitrequest = mN_req & ~grantN. A master holds its request stable until waitrequest is low (Avalon rule).
- Memory drive on a granted in-range access:
  - mem_chipselect = 1; mem_address, mem_byteenable, mem_writedata muxed from the winner.
  - mem_write = winner write.
  - With no grant: mem_chipselect = 0, mem_write = 0.
- Read latency: a read granted in cycle N produces mN_readdatavalid = 1 in cycle N+1.
  - mN_readdata = mem_readdata in that cycle.
  - The tag is held in registers rd_pend (valid) and rd_tag (master id).
  - The readdata output not being returned stays 0.
- Back-to-back: a new grant is allowed every cycle, including a read followed by a write, read followed by read, and reads alternating between masters. Throughput is 1 access/cycle.
- Out-of-range access (address >= DEPTH), read or write:
  - The access is granted, so waitrequest drops normally.
  - mem_chipselect = 0 and mem_write = 0.
  - A read still gets readdatavalid in N+1, with readdata = 0.
  - oob_count increments (saturates at 16'hFFFF); oob_irq is set.
- oob_clear: clears oob_count and oob_irq. If an out-of-range access occurs in the same cycle, set wins: count = 1, irq = 1.
- Reset state:
  - last_grant = 1, so master 0 wins the first contention.
  - rd_pend = 0; all readdatavalid = 0; readdata = 0.
  - oob_count = 0; oob_irq = 0.
  - waitrequest follows the combinational rule; during reset both waitrequests = 1.
  - mem_chipselect = 0; mem_clken = 1.
- Reset asserted while a read is pending: the pending read is discarded; no readdatavalid after reset release.
- The arbiter has no FSM beyond last_grant, rd_pend, rd_tag and the OOB registers.

Decomposition:
- Shared package adc_qsys_ram_pkg holds:
  - constants RAM_ADDR_W = 15, RAM_DATA_W = 32, RAM_DEPTH = 32000;
  - enum prio_mode_e {PRIO_RR, PRIO_FIXED0};
  - typedef mem_req_t {addr, be, wdata, rd, wr}.
- One sub-module, adc_qsys_rr_grant2: the 2-way grant logic plus the last_grant register.
- The top level holds the muxing, read tagging and OOB counter.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 5 -> mem_chipselect = 1, mem_write = 1, mem_address = 5, m0_waitrequest = 0 in the same cycle.
- m1 reads addr 5 -> m1_readdatavalid = 1 exactly one cycle later with 0xDEADBEEF; m0_readdatavalid stays 0.
- Both masters hold reads to addr 1/2 for 4 cycles, PRIO_MODE=0 -> grants alternate m0, m1, m0, m1; each waitrequest is low on alternate cycles.
- Same contention with PRIO_MODE=1 -> m0 granted every cycle; m1_waitrequest stays 1.
- m1 reads addr 32000 -> mem_chipselect = 0; m1_readdatavalid in N+1 with data 0; oob_count = 1; oob_irq = 1. Then oob_clear -> both return to 0.
- m0 read granted, then reset asserted in cycle N+1 before the edge -> no readdatavalid after release; last_grant back to 1; oob_count = 0.
